mul_trunc_seq: RTL
==================

Name: mul_trunc_seq

Overview:
- Iterative, parametrised successor to the combinational truncated 16x16 unsigned multipliers.
- Computes an unsigned W x W product one B bit per cycle. Only partial-product bits in columns >= a runtime-selectable truncation column are accumulated.
- trunc_col=0 gives the exact product. trunc_col=2W-8 with W=16 gives the top-8-bit approximate behaviour of the existing approximate multiplier.
- Sits in the FPGA approximate-arithmetic library as a low-LUT, multi-cycle alternative, with valid/ready streaming on both sides.

Parameters:
- W, 16, operand width in bits (>= 2).
- CW, $clog2(2*W)+1, width of trunc_col; derived, not overridden.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands and trunc_col are valid.
- in_ready  output  1  block can accept an operation.
- in_a  input  W  multiplicand A, unsigned.
- in_b  input  W  multiplier B, unsigned.
- trunc_col  input  CW  lowest partial-product column kept; 0 = exact.
- out_valid  output  1  out_p holds a finished result.
- out_ready  input  1  consumer accepts out_p.
- out_p  output  2W  truncated product.

Behaviour:
- Function: out_p = (sum over i,j in [0,W-1] with i+j >= trunc_col of a_i*b_j*2^(i+j)) mod 2^(2W).
  - trunc_col is evaluated as an unsigned value; any trunc_col >= 2W yields out_p = 0.
  - No rounding or compensation constant.
- Reset (rst=1 at an edge): state=IDLE, in_ready=1, out_valid=0, out_p=0, accumulator=0, counter=0.
  - Applies from any state. An operation in flight is discarded and no result is emitted.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - At an edge with in_valid=1: latch in_a, in_b, trunc_col; clear accumulator; cnt=0; go to BUSY.
- BUSY:
  - in_ready=0, out_valid=0.
  - Each edge: acc <= acc + ((A & colmask(cnt)) << cnt) if B[cnt]=1, else acc unchanged. Addition is modulo 2^(2W).
  - colmask(j) keeps A bits i with i+j >= trunc_col, i.e. i >= max(0, trunc_col-j).
  - Exactly W BUSY edges. On the edge where cnt=W-1, go to DONE. cnt does not wrap beyond W-1.
- DONE:
  - out_valid=1, out_p=acc, in_ready=0.
  - out_p and out_valid are held stable while out_ready=0, for arbitrarily many cycles.
  - At an edge with out_ready=1: go to IDLE. out_valid falls and in_ready rises in the next cycle.
- Latency: accept edge E0; out_valid=1 after edge E0+W. Throughput: one operation per W+2 cycles with out_ready tied high. No overlap of consecutive operations.
- Operand isolation:
  - Input changes outside an accepting IDLE edge have no effect.
  - in_valid during BUSY or DONE is ignored and not queued.
  - out_ready in IDLE or BUSY is ignored.
- out_p is registered and keeps its last value after the DONE->IDLE transition until the next DONE. Checkers sample it only when out_valid=1.

Decomposition:
- Shared package mul_approx_pkg:
  - state enum (IDLE, BUSY, DONE);
  - function clog2-based CW helper;
  - function colmask(width, trunc_col, j) returning a W-bit mask;
  - default W constant.
- One natural sub-module: mul_trunc_row. It is combinational and produces the shifted, masked partial-product row (A, B bit, cnt, trunc_col -> 2W-bit row). The top level holds the FSM, counter, accumulator and handshake.

Test Plan (W=16):
- Exact, full scale: A=0xFFFF, B=0xFFFF, trunc_col=0 -> out_p=0xFFFE0001; out_valid exactly 16 cycles after the accept edge.
- Approximate, matching the existing approximate design: A=0xFFFF, B=0xFFFF, trunc_col=24 -> out_p=0xF7000000. Also A=0x8000, B=0x8000, trunc_col=24 -> 0x40000000.
- Fully truncated rows: A=0x00FF, B=0xFFFF, trunc_col=24 -> 0x00000000. Same operands with trunc_col=0 -> 0x00FEFF01. trunc_col=32 with any operands -> 0.
- Backpressure: complete an operation with out_ready=0 for 5 cycles.
  - Required: out_valid=1 and out_p stable throughout; in_ready=0; in_valid pulses ignored.
  - Raising out_ready -> in_ready=1 on the next cycle.
- Reset mid-operation: accept A=0x1234, B=0x5678, assert rst at BUSY cycle 7.
  - Next cycle: IDLE, in_ready=1, out_valid=0, out_p=0.
  - A new operation 3 x 5 (trunc_col=0) then returns 0x0000000F.
- Random regression: 10k random A, B, trunc_col in [0,33] with random out_ready stalls. Compare against the golden function above, and check no result is lost or duplicated.

Source files
------------

// File: rtl/mul_approx_pkg.sv
// Shared types and helpers for the approximate-arithmetic multipliers.
// colmask selects the A bits whose partial-product column survives truncation.
package mul_approx_pkg;

   localparam int W_DEF = 16;
   localparam int MAX_W = 64;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   function automatic int calc_cw(input int w);
      return $clog2(2 * w) + 1;
   endfunction

   // Bit i is set when column i+j is at or above tc; bits >= width are zero.
   function automatic logic [MAX_W-1:0] colmask(input int width, input int tc, input int j);
      logic [MAX_W-1:0] m;
      m = '0;
      for (int i = 0; i < MAX_W; i++)
         m[i] = (i < width) && (i + j >= tc);
      return m;
   endfunction

endpackage

// File: rtl/mul_trunc_row.sv
// Combinational partial-product row: A masked to the kept columns, shifted by
// the current B bit position, zeroed when that B bit is clear.
module mul_trunc_row
   import mul_approx_pkg::*;
#(
   parameter int W    = W_DEF,
   parameter int CW   = calc_cw(W),
   parameter int CNTW = $clog2(W)
) (
   input  logic [W-1:0]    a,
   input  logic            b_bit,
   input  logic [CNTW-1:0] cnt,
   input  logic [CW-1:0]   trunc_col,
   output logic [2*W-1:0]  row
);

   logic [W-1:0] mask;

   always_comb begin
      mask = W'(colmask(W, int'(trunc_col), int'(cnt)));
      row  = '0;
      if (b_bit)
         row = {{W{1'b0}}, a & mask} << cnt;
   end

endmodule

// File: rtl/mul_trunc_seq.sv
// Iterative truncated W x W unsigned multiplier, one B bit per cycle, with
// valid/ready on both sides and no overlap between operations.
module mul_trunc_seq
   import mul_approx_pkg::*;
#(
   parameter  int W  = W_DEF,
   localparam int CW = calc_cw(W)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [W-1:0]   in_a,
   input  logic [W-1:0]   in_b,
   input  logic [CW-1:0]  trunc_col,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [2*W-1:0] out_p
);

   localparam int CNTW = $clog2(W);

   state_t          state;
   logic [W-1:0]    a_q, b_q;
   logic [CW-1:0]   tc_q;
   logic [CNTW-1:0] cnt;
   logic [2*W-1:0]  acc, row;

   mul_trunc_row #(.W(W), .CW(CW), .CNTW(CNTW)) u_row (
      .a         (a_q),
      .b_bit     (b_q[cnt]),
      .cnt       (cnt),
      .trunc_col (tc_q),
      .row       (row)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         out_p     <= '0;
         acc       <= '0;
         cnt       <= '0;
         a_q       <= '0;
         b_q       <= '0;
         tc_q      <= '0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               a_q      <= in_a;
               b_q      <= in_b;
               tc_q     <= trunc_col;
               acc      <= '0;
               cnt      <= '0;
               in_ready <= 1'b0;
               state    <= BUSY;
            end
            BUSY: begin
               acc <= acc + row;
               if (cnt == CNTW'(W - 1)) begin
                  // Final row folds straight into the output register.
                  out_p     <= acc + row;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DONE: if (out_ready) begin
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
